// File: rtl/prl_rx_pkg.sv
// Shared definitions for the PD protocol-layer blocks (tx and prl_rx).
// Holds receive FSM state encodings, SOP* frame-type codes, header field
// positions, the Soft Reset message type and small header helpers.
package prl_rx_pkg;

  typedef enum logic [2:0] {
    RX_WAIT_FOR_PHY_MESSAGE = 3'd0,
    RX_CHECK_TYPE           = 3'd1,
    RX_SEND_GOODCRC         = 3'd2,
    RX_CHECK_MESSAGEID      = 3'd3,
    RX_STORE_MESSAGEID      = 3'd4,
    RX_REPORT_HARD_RESET    = 3'd5
  } rxState_t;

  localparam logic [2:0] FRAME_SOP         = 3'd0;
  localparam logic [2:0] FRAME_SOP_P       = 3'd1;
  localparam logic [2:0] FRAME_SOP_PP      = 3'd2;
  localparam logic [2:0] FRAME_SOP_DBG_P   = 3'd3;
  localparam logic [2:0] FRAME_SOP_DBG_PP  = 3'd4;
  localparam logic [2:0] FRAME_HARD_RESET  = 3'd5;
  localparam logic [2:0] FRAME_CABLE_RESET = 3'd6;
  localparam logic [2:0] FRAME_RESERVED    = 3'd7;

  // Number of SOP* types that carry MessageIDs (codes 0..4).
  localparam int NUM_SOP_TYPES = 5;

  localparam int HDR_MSGTYPE_LSB = 0;
  localparam int HDR_MSGTYPE_W   = 5;
  localparam int HDR_MSGID_LSB   = 9;
  localparam int HDR_MSGID_W     = 3;
  localparam int HDR_NDO_LSB     = 12;
  localparam int HDR_NDO_W       = 3;

  localparam logic [4:0] MSG_SOFT_RESET = 5'b01101;

  function automatic logic [2:0] msgIdOf(input logic [15:0] hdr);
    return hdr[HDR_MSGID_LSB +: HDR_MSGID_W];
  endfunction

  function automatic logic isSoftReset(input logic [15:0] hdr);
    return (hdr[HDR_NDO_LSB +: HDR_NDO_W] == 3'd0) &&
           (hdr[HDR_MSGTYPE_LSB +: HDR_MSGTYPE_W] == MSG_SOFT_RESET);
  endfunction

endpackage

// File: rtl/prl_rx_msgid.sv
// msgid_table: last-received MessageID plus valid flag for each SOP* type.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   rdIdx/rdValid/rdId  combinational read of one entry
//   wrEn/wrIdx/wrId   store an ID and mark the entry valid
//   clrEn/clrIdx      clear one entry's valid flag
//   clrAll            clear every valid flag (highest priority)
module msgid_table
  import prl_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rdIdx,
  output logic       rdValid,
  output logic [2:0] rdId,
  input  logic       wrEn,
  input  logic [2:0] wrIdx,
  input  logic [2:0] wrId,
  input  logic       clrEn,
  input  logic [2:0] clrIdx,
  input  logic       clrAll
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_SOP_TYPES - 1);

  logic [2:0]               ids [NUM_SOP_TYPES];
  logic [NUM_SOP_TYPES-1:0] valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < NUM_SOP_TYPES; i++) ids[i] <= '0;
    end else if (clrAll) begin
      valid <= '0;
    end else begin
      // Write is placed after the clear so a same-cycle write leaves the entry valid.
      if (clrEn && clrIdx <= LAST_IDX) valid[clrIdx] <= 1'b0;
      if (wrEn && wrIdx <= LAST_IDX) begin
        ids[wrIdx]   <= wrId;
        valid[wrIdx] <= 1'b1;
      end
    end
  end

  assign rdValid = (rdIdx <= LAST_IDX) ? valid[rdIdx] : 1'b0;
  assign rdId    = (rdIdx <= LAST_IDX) ? ids[rdIdx]   : 3'd0;

endmodule

// File: rtl/prl_rx.sv
// prl_rx: PD protocol-layer receive state machine. Filters received frames
// by type/enable, requests GoodCRC, drops duplicates by MessageID and hands
// accepted messages to the RX buffer; reports Hard/Cable Reset.
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   PhyMessageValid, RxFrameType, RxHeader   frame from PHY
//   RxDetectEnable, RxBufFull                TCPM receive configuration/status
//   GoodCRCDone / GoodCRCReq, GoodCRCMsgID, GoodCRCFrameType   GoodCRC handshake
//   StoreMessage, StoredHeader, StoredFrameType                 RX buffer write
//   Alert_ReceivedSOP, Alert_ReceivedHardReset                  alert pulses
//
// state                   | meaning
// RX_WAIT_FOR_PHY_MESSAGE | idle, accepting a PHY frame
// RX_CHECK_TYPE           | filter on frame type, enable mask, buffer full
// RX_SEND_GOODCRC         | GoodCRC requested, timeout counting down
// RX_CHECK_MESSAGEID      | duplicate / Soft Reset check against table
// RX_STORE_MESSAGEID      | record ID, pulse store and SOP alert
// RX_REPORT_HARD_RESET    | clear table, pulse hard-reset alert
module prl_rx
  import prl_rx_pkg::*;
#(
  parameter int GOODCRC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PhyMessageValid,
  input  logic [2:0]  RxFrameType,
  input  logic [15:0] RxHeader,
  input  logic [6:0]  RxDetectEnable,
  input  logic        RxBufFull,
  input  logic        GoodCRCDone,
  output logic        GoodCRCReq,
  output logic [2:0]  GoodCRCMsgID,
  output logic [2:0]  GoodCRCFrameType,
  output logic        StoreMessage,
  output logic [15:0] StoredHeader,
  output logic [2:0]  StoredFrameType,
  output logic        Alert_ReceivedSOP,
  output logic        Alert_ReceivedHardReset
);

  localparam int TW = $clog2(GOODCRC_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(GOODCRC_TIMEOUT - 1);

  rxState_t    state;
  logic [15:0] hdrLatch;
  logic [2:0]  typeLatch;
  logic [TW-1:0] timer;

  logic       rdValid;
  logic [2:0] rdId;
  logic [7:0] enableExt;
  logic       typeEnabled;
  logic       typeIsReset;
  logic       softReset;
  logic       duplicate;

  // Code 7 has no enable bit; the extra zero makes it always disabled.
  assign enableExt   = {1'b0, RxDetectEnable};
  assign typeEnabled = enableExt[typeLatch];
  assign typeIsReset = (typeLatch == FRAME_HARD_RESET) || (typeLatch == FRAME_CABLE_RESET);
  assign softReset   = isSoftReset(hdrLatch);
  assign duplicate   = rdValid && (rdId == msgIdOf(hdrLatch));

  msgid_table uTable (
    .clk     (clk),
    .reset   (reset),
    .rdIdx   (typeLatch),
    .rdValid (rdValid),
    .rdId    (rdId),
    .wrEn    (state == RX_STORE_MESSAGEID),
    .wrIdx   (typeLatch),
    .wrId    (msgIdOf(hdrLatch)),
    .clrEn   ((state == RX_CHECK_MESSAGEID) && softReset),
    .clrIdx  (typeLatch),
    .clrAll  (state == RX_REPORT_HARD_RESET)
  );

  // Outputs are registered on the transition into their state, so each is
  // high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= RX_WAIT_FOR_PHY_MESSAGE;
      hdrLatch                <= '0;
      typeLatch               <= '0;
      timer                   <= '0;
      GoodCRCReq              <= 1'b0;
      GoodCRCMsgID            <= '0;
      GoodCRCFrameType        <= '0;
      StoreMessage            <= 1'b0;
      StoredHeader            <= '0;
      StoredFrameType         <= '0;
      Alert_ReceivedSOP       <= 1'b0;
      Alert_ReceivedHardReset <= 1'b0;
    end else begin
      GoodCRCReq              <= 1'b0;
      GoodCRCMsgID            <= '0;
      GoodCRCFrameType        <= '0;
      StoreMessage            <= 1'b0;
      StoredHeader            <= '0;
      StoredFrameType         <= '0;
      Alert_ReceivedSOP       <= 1'b0;
      Alert_ReceivedHardReset <= 1'b0;
      case (state)
        RX_WAIT_FOR_PHY_MESSAGE: begin
          if (PhyMessageValid) begin
            hdrLatch  <= RxHeader;
            typeLatch <= RxFrameType;
            state     <= RX_CHECK_TYPE;
          end
        end
        RX_CHECK_TYPE: begin
          if (typeIsReset && typeEnabled) begin
            state                   <= RX_REPORT_HARD_RESET;
            Alert_ReceivedHardReset <= 1'b1;
          end else if (!typeEnabled || typeIsReset || RxBufFull) begin
            // Reserved type lands here through its zero enable bit.
            state <= RX_WAIT_FOR_PHY_MESSAGE;
          end else begin
            state            <= RX_SEND_GOODCRC;
            timer            <= TIMER_LOAD;
            GoodCRCReq       <= 1'b1;
            GoodCRCMsgID     <= msgIdOf(hdrLatch);
            GoodCRCFrameType <= typeLatch;
          end
        end
        RX_SEND_GOODCRC: begin
          if (GoodCRCDone) begin
            state <= RX_CHECK_MESSAGEID;
          end else if (timer == '0) begin
            state <= RX_WAIT_FOR_PHY_MESSAGE;
          end else begin
            timer            <= timer - 1'b1;
            GoodCRCReq       <= 1'b1;
            GoodCRCMsgID     <= msgIdOf(hdrLatch);
            GoodCRCFrameType <= typeLatch;
          end
        end
        RX_CHECK_MESSAGEID: begin
          if (softReset || !duplicate) begin
            state             <= RX_STORE_MESSAGEID;
            StoreMessage      <= 1'b1;
            StoredHeader      <= hdrLatch;
            StoredFrameType   <= typeLatch;
            Alert_ReceivedSOP <= 1'b1;
          end else begin
            state <= RX_WAIT_FOR_PHY_MESSAGE;
          end
        end
        RX_STORE_MESSAGEID:   state <= RX_WAIT_FOR_PHY_MESSAGE;
        RX_REPORT_HARD_RESET: state <= RX_WAIT_FOR_PHY_MESSAGE;
        default:              state <= RX_WAIT_FOR_PHY_MESSAGE;
      endcase
    end
  end

endmodule

// File: tb/tb_prl_rx.sv
module tb_prl_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        PhyMessageValid;
  logic [2:0]  RxFrameType;
  logic [15:0] RxHeader;
  logic [6:0]  RxDetectEnable;
  logic        RxBufFull;
  logic        GoodCRCDone;
  logic        GoodCRCReq;
  logic [2:0]  GoodCRCMsgID;
  logic [2:0]  GoodCRCFrameType;
  logic        StoreMessage;
  logic [15:0] StoredHeader;
  logic [2:0]  StoredFrameType;
  logic        Alert_ReceivedSOP;
  logic        Alert_ReceivedHardReset;

  typedef struct packed {
    logic [15:0] hdr;
    logic [2:0]  ft;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   storeCount  = 0;
  int   hrCount     = 0;

  prl_rx #(.GOODCRC_TIMEOUT(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .PhyMessageValid         (PhyMessageValid),
    .RxFrameType             (RxFrameType),
    .RxHeader                (RxHeader),
    .RxDetectEnable          (RxDetectEnable),
    .RxBufFull               (RxBufFull),
    .GoodCRCDone             (GoodCRCDone),
    .GoodCRCReq              (GoodCRCReq),
    .GoodCRCMsgID            (GoodCRCMsgID),
    .GoodCRCFrameType        (GoodCRCFrameType),
    .StoreMessage            (StoreMessage),
    .StoredHeader            (StoredHeader),
    .StoredFrameType         (StoredFrameType),
    .Alert_ReceivedSOP       (Alert_ReceivedSOP),
    .Alert_ReceivedHardReset (Alert_ReceivedHardReset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mkHdr(input logic [2:0] id, input logic [2:0] ndo,
                                        input logic [4:0] mt);
    return {1'b0, ndo, id, 4'b0000, mt};
  endfunction

  // Output monitor: pops the scoreboard on every store.
  always @(negedge clk) begin
    if (StoreMessage || Alert_ReceivedSOP)
      check("sop_alert_coincident", {31'd0, Alert_ReceivedSOP}, {31'd0, StoreMessage});
    if (Alert_ReceivedHardReset) hrCount++;
    if (StoreMessage) begin
      storeCount++;
      if (sbq.size() == 0) begin
        check("unexpected_store", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("stored_header", {16'd0, StoredHeader}, {16'd0, e.hdr});
        check("stored_type", {29'd0, StoredFrameType}, {29'd0, e.ft});
      end
    end
  end

  // One frame from the PHY; doneAfter<=0 means GoodCRCDone is never given.
  task automatic runFrame(input string tag, input logic [2:0] ft, input logic [15:0] hdr,
                          input logic [6:0] en, input logic full, input int doneAfter,
                          input int expReq, input bit expStore, input int expHr);
    int reqSeen = 0;
    int store0  = storeCount;
    int hr0     = hrCount;
    if (expStore) sbq.push_back({hdr, ft});
    @(posedge clk); #1;
    RxFrameType     = ft;
    RxHeader        = hdr;
    RxDetectEnable  = en;
    RxBufFull       = full;
    PhyMessageValid = 1'b1;
    @(posedge clk); #1;
    PhyMessageValid = 1'b0;
    RxHeader        = ~hdr;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (GoodCRCReq) begin
        reqSeen++;
        if (reqSeen == 1) begin
          check({tag, " msgid"}, {29'd0, GoodCRCMsgID}, {29'd0, hdr[11:9]});
          check({tag, " crc_type"}, {29'd0, GoodCRCFrameType}, {29'd0, ft});
        end
      end
      GoodCRCDone = GoodCRCReq && (doneAfter > 0) && (reqSeen == doneAfter);
    end
    GoodCRCDone = 1'b0;
    check({tag, " req_cycles"}, reqSeen, expReq);
    check({tag, " stores"}, storeCount - store0, expStore ? 1 : 0);
    check({tag, " hr_alerts"}, hrCount - hr0, expHr);
    check({tag, " sb_empty"}, sbq.size(), 0);
  endtask

  initial begin
    int store0;
    int reqAfter;
    bit seen;
    reset           = 1'b0;
    PhyMessageValid = 1'b0;
    RxFrameType     = 3'd0;
    RxHeader        = 16'd0;
    RxDetectEnable  = 7'h7F;
    RxBufFull       = 1'b0;
    GoodCRCDone     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {GoodCRCReq, GoodCRCMsgID, GoodCRCFrameType, StoreMessage, StoredHeader,
           StoredFrameType, Alert_ReceivedSOP, Alert_ReceivedHardReset}, 32'd0);
    reset = 1'b1;

    runFrame("sop_id3",       3'd0, mkHdr(3'd3, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  2,  1'b1, 0);
    runFrame("sop_id3_dup",   3'd0, mkHdr(3'd3, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  2,  1'b0, 0);
    runFrame("sop_id7",       3'd0, mkHdr(3'd7, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  2,  1'b1, 0);
    runFrame("sop_id0_wrap",  3'd0, mkHdr(3'd0, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  2,  1'b1, 0);
    runFrame("soft_reset_id0",3'd0, mkHdr(3'd0, 3'd0, 5'h0D), 7'h7F, 1'b0, 1,  1,  1'b1, 0);
    runFrame("sopp_disabled", 3'd1, mkHdr(3'd3, 3'd1, 5'd1),  7'h7D, 1'b0, 2,  0,  1'b0, 0);
    runFrame("sop_buf_full",  3'd0, mkHdr(3'd1, 3'd1, 5'd1),  7'h7F, 1'b1, 2,  0,  1'b0, 0);
    runFrame("reserved_type", 3'd7, mkHdr(3'd1, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  0,  1'b0, 0);
    runFrame("sopp_id3",      3'd1, mkHdr(3'd3, 3'd1, 5'd1),  7'h7F, 1'b0, 3,  3,  1'b1, 0);
    runFrame("crc_timeout",   3'd0, mkHdr(3'd2, 3'd1, 5'd1),  7'h7F, 1'b0, 0,  16, 1'b0, 0);
    runFrame("done_last_cyc", 3'd0, mkHdr(3'd2, 3'd1, 5'd1),  7'h7F, 1'b0, 16, 16, 1'b1, 0);
    runFrame("sopp_id3_dup",  3'd1, mkHdr(3'd3, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  2,  1'b0, 0);
    runFrame("hard_reset",    3'd5, mkHdr(3'd0, 3'd0, 5'd0),  7'h7F, 1'b0, 2,  0,  1'b0, 1);
    runFrame("sopp_id3_again",3'd1, mkHdr(3'd3, 3'd1, 5'd1),  7'h7F, 1'b0, 2,  2,  1'b1, 0);
    runFrame("cable_rst_off", 3'd6, mkHdr(3'd0, 3'd0, 5'd0),  7'h3F, 1'b0, 2,  0,  1'b0, 0);
    runFrame("cable_rst_on",  3'd6, mkHdr(3'd0, 3'd0, 5'd0),  7'h7F, 1'b1, 2,  0,  1'b0, 1);

    // Reset asserted while GoodCRC is being requested.
    store0 = storeCount;
    @(posedge clk); #1;
    RxFrameType     = 3'd0;
    RxHeader        = mkHdr(3'd6, 3'd1, 5'd1);
    RxDetectEnable  = 7'h7F;
    RxBufFull       = 1'b0;
    PhyMessageValid = 1'b1;
    @(posedge clk); #1;
    PhyMessageValid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (GoodCRCReq) seen = 1'b1;
    end
    check("midreset_req_seen", {31'd0, seen}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_outputs",
          {GoodCRCReq, GoodCRCMsgID, GoodCRCFrameType, StoreMessage, StoredHeader,
           StoredFrameType, Alert_ReceivedSOP, Alert_ReceivedHardReset}, 32'd0);
    reset       = 1'b1;
    GoodCRCDone = 1'b1;
    reqAfter    = 0;
    repeat (20) begin
      @(negedge clk);
      if (GoodCRCReq) reqAfter++;
    end
    GoodCRCDone = 1'b0;
    check("midreset_no_req", reqAfter, 0);
    check("midreset_no_store", storeCount - store0, 0);

    // Table cleared by reset: the last SOP' ID is accepted once more.
    runFrame("post_reset_sopp", 3'd1, mkHdr(3'd3, 3'd1, 5'd1), 7'h7F, 1'b0, 2, 2, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
